// File: rtl/uart_rx_word_assembler.sv
// uart_rx_word_assembler: packs DEPTH consecutive UART bytes into one
// parallel word; element 0 holds the first byte received.
//
// Ports:
//   clk, arst          clock, asynchronous active-high reset
//   up_valid/up_ready  byte handshake from the UART receiver
//   up_data            received byte
//   down_valid/ready   word handshake to the consumer
//   down_data          assembled word, element k = k-th byte
//   level              bytes currently held (0..DEPTH)
//   timeout_o          one-cycle pulse when a partial word is dropped
//
// Optional feature macro: UART_RX_ASM_TIMEOUT_EN enables the idle
// counter that discards a stale partial word after TIMEOUT cycles.
// Without it, partial words are held indefinitely and timeout_o is 0.

module uart_rx_word_assembler #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          up_valid,
    output logic                          up_ready,
    input  logic [WIDTH-1:0]              up_data,
    output logic                          down_valid,
    input  logic                          down_ready,
    output logic [DEPTH-1:0][WIDTH-1:0]   down_data,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          timeout_o
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    // Elaboration-time sanity check on the configuration.
    if (DEPTH < 2 || TIMEOUT < 2) begin : g_bad_params
        $error("uart_rx_word_assembler: DEPTH and TIMEOUT must be >= 2");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                        state;
    logic [PW-1:0]                 wr_ptr;
    logic [DEPTH-1:0][WIDTH-1:0]   buffer;

    // Handshake outputs come straight from the state register, so
    // neither up_valid nor down_ready can reach up_ready combinationally.
    assign up_ready   = (state == COLLECT);
    assign down_valid = (state == FULL);
    assign down_data  = buffer;

`ifdef UART_RX_ASM_TIMEOUT_EN

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] idle_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= COLLECT;
            wr_ptr    <= '0;
            level     <= '0;
            buffer    <= '0;
            timeout_o <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            timeout_o <= 1'b0;
            unique case (state)
                COLLECT: begin
                    if (up_valid) begin
                        // An accepted byte always wins over expiry.
                        buffer[wr_ptr] <= up_data;
                        level          <= level + LW'(1);
                        idle_cnt       <= '0;
                        if (wr_ptr == PW'(DEPTH-1)) begin
                            wr_ptr <= '0;
                            state  <= FULL;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                    end else if (level == '0) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == CW'(TIMEOUT-1)) begin
                        // Stale partial word: drop it and restart at
                        // element 0. Buffer contents are left as is.
                        wr_ptr    <= '0;
                        level     <= '0;
                        idle_cnt  <= '0;
                        timeout_o <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                FULL: begin
                    idle_cnt <= '0;
                    if (down_ready) begin
                        state <= COLLECT;
                        level <= '0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

`else

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= COLLECT;
            wr_ptr <= '0;
            level  <= '0;
            buffer <= '0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (up_valid) begin
                        buffer[wr_ptr] <= up_data;
                        level          <= level + LW'(1);
                        if (wr_ptr == PW'(DEPTH-1)) begin
                            wr_ptr <= '0;
                            state  <= FULL;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                    end
                end
                FULL: begin
                    if (down_ready) begin
                        state <= COLLECT;
                        level <= '0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign timeout_o = 1'b0;

`endif

endmodule

// File: doc/uart_rx_word_assembler.md
# uart_rx_word_assembler

Receive-side counterpart of the UART TX word serializer. It accepts one byte at a time from the UART receiver over a valid/ready handshake, packs DEPTH consecutive bytes into one parallel word, and presents the word downstream over valid/ready. Byte order matches the TX serializer: the first byte received lands in element 0. It sits between the UART RX deserializer and the DSP/FFT sample input logic.

## Interface
- WIDTH, 8: bits per element (one UART byte).
- DEPTH, 4: elements per assembled word; ≥2.
- TIMEOUT, 1000: idle-cycle limit for a partial word; only used with UART_RX_ASM_TIMEOUT_EN; ≥2.

- clk  in  1  clock; all logic on rising edge.
- arst  in  1  asynchronous active-high reset.
- up_valid  in  1  byte available from UART RX.
- up_ready  out  1  assembler can accept a byte.
- up_data  in  WIDTH  received byte.
- down_valid  out  1  assembled word available.
- down_ready  in  1  consumer accepts word.
- down_data  out  [DEPTH-1:0][WIDTH-1:0]  assembled word; element k = k-th byte received.
- level  out  $clog2(DEPTH+1)  bytes currently held (0..DEPTH).
- timeout_o  out  1  one-cycle pulse: partial word discarded.

## Operation
- Clock is clk; reset is arst, asynchronous and active-high.
- Two states: COLLECT, FULL. Reset → COLLECT, wr_ptr=0, level=0, down_data=0, down_valid=0, timeout_o=0, idle counter=0; up_ready=1 during and after reset.
- COLLECT: up_ready=1, down_valid=0. On up_valid&up_ready: buffer[wr_ptr] ← up_data, level+1. If wr_ptr==DEPTH-1: wr_ptr ← 0, state ← FULL; else wr_ptr+1.
- FULL: up_ready=0, down_valid=1, level=DEPTH, down_data stable. On down_valid&down_ready: state ← COLLECT, level ← 0. Bytes offered while FULL are back-pressured, never dropped or overwritten.
- up_ready and down_valid are decoded from registered state only; no combinational path up_valid→up_ready or down_ready→up_ready.
- Buffer elements not yet rewritten keep old contents; down_data only guaranteed while down_valid=1.
- arst mid-word or mid-FULL: immediate return to reset values; partial/pending word lost.

## Timing
- Last byte accepted at edge N → down_valid=1 after edge N (1-cycle latency).
- Word taken at edge M → up_ready=1 after edge M; earliest next byte accepted at edge M+1.
- Peak throughput: DEPTH bytes per DEPTH+1 cycles with down_ready held high.
- level updates on the same edge as the accepting handshake.
- Timeout (macro on): idle counter counts cycles in COLLECT with level>0 and no accepted byte; cleared on every accepted byte and whenever level=0. When counter reaches TIMEOUT-1 and no byte accepted that cycle: next edge wr_ptr←0, level←0, timeout_o=1 for exactly one cycle. Byte accepted in the expiry cycle wins: stored, counter cleared, no timeout.

## Configuration
- UART_RX_ASM_TIMEOUT_EN defined: idle counter and discard logic per Timing; timeout_o driven.
- Not defined: no counter; partial words held indefinitely; timeout_o tied 0; TIMEOUT ignored.

## Test plan
- Reset: arst=1 mid-operation → down_valid=0, level=0, up_ready=1, timeout_o=0 immediately (asynchronously); after release, first byte lands in element 0.
- Basic: DEPTH=4, bytes 0x11,0x22,0x33,0x44 back-to-back, down_ready=1 → down_data={0x44,0x33,0x22,0x11} (elem0=0x11), down_valid high one cycle after 4th accept, up_ready high the cycle after.
- Backpressure: word full, down_ready=0 for 20 cycles while up_valid=1 with 0x55 → up_ready=0, down_data unchanged, level=4; raise down_ready → word taken, 0x55 accepted next cycle as element 0.
- Throughput: 12 continuous bytes, down_ready=1 → 3 words in 15 cycles, bytes in order, none lost.
- Timeout (macro on, TIMEOUT=8): accept 2 bytes then idle → timeout_o pulses once 8 idle cycles after 2nd accept, level 2→0; next 4 bytes form a clean word.
- Timeout race / macro off: byte arrives in expiry cycle → no pulse, level=3; with macro off, 2 bytes then 10000 idle cycles → level stays 2, timeout_o=0.
